// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Arbitrates one physical-memory port between an instruction
//               cache (read-only) and a data cache (read + writeback).
//               A grant lasts for exactly one memory transaction and ends
//               on pmem_resp. When both caches request together, the one
//               that was not granted last wins.
// Ports       :
//   clk, reset                      - clock, synchronous active-high reset
//   i_pmem_read/address             - I-cache line-read request
//   i_pmem_rdata/resp               - I-cache returned line and completion
//   d_pmem_read/write/address/wdata - D-cache read / writeback request
//   d_pmem_rdata/resp               - D-cache returned line and completion
//   pmem_read/write/address/wdata   - command to physical memory
//   pmem_rdata/resp                 - physical memory read line, completion
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
  parameter int line_width = 256,
  parameter int addr_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction cache
  input  logic                  i_pmem_read,
  input  logic [addr_width-1:0] i_pmem_address,
  output logic [line_width-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  // data cache
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [addr_width-1:0] d_pmem_address,
  input  logic [line_width-1:0] d_pmem_wdata,
  output logic [line_width-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  // physical memory
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [addr_width-1:0] pmem_address,
  output logic [line_width-1:0] pmem_wdata,
  input  logic [line_width-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       i_req;
  logic       d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // Next-state and round-robin bookkeeping. last_grant is updated on the
  // same edge that enters a SERVE state, so a tie is resolved against the
  // most recent grant, not the one before it.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          if (last_grant_q == GRANT_D) begin
            state_d      = SERVE_I;
            last_grant_d = GRANT_I;
          end else begin
            state_d      = SERVE_D;
            last_grant_d = GRANT_D;
          end
        end else if (i_req) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
        end
      end
      // A grant is held until memory completes, even if the requester
      // withdraws, so a transaction in flight is never orphaned.
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Command and response steering. Read data fans out to both caches
  // unconditionally; only the resp pulse qualifies it.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = i_pmem_address;
    pmem_wdata   = d_pmem_wdata;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
    case (state_q)
      SERVE_I: begin
        pmem_read   = i_pmem_read;
        i_pmem_resp = pmem_resp;
      end
      SERVE_D: begin
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        d_pmem_resp  = pmem_resp;
      end
      default: begin
        pmem_read = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Self-checking bench for cache_arbiter. Directed stimulus
//               drives both caches and plays the memory side; each memory
//               response pushes the expected requester and line into a
//               queue that a negedge monitor pops whenever a resp appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam logic [LW-1:0] WD_A5 = {32{8'ha5}};
  localparam bit WHO_I = 1'b0;
  localparam bit WHO_D = 1'b1;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(.line_width(LW), .addr_width(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            who;
    logic [LW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic chk(input string name, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (i_pmem_resp || d_pmem_resp) begin
      if (i_pmem_resp && d_pmem_resp) begin
        n_total++;
        n_bad++;
        $display("FAIL resp_both: got i=1 d=1 expected one of them");
      end else if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL resp_unexpected: got i=%0b d=%0b expected none",
                 i_pmem_resp, d_pmem_resp);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_who", {255'd0, d_pmem_resp}, {255'd0, e.who});
        if (d_pmem_resp) chk("d_rdata", d_pmem_rdata, e.data);
        else             chk("i_rdata", i_pmem_rdata, e.data);
      end
    end
  end

  // Entered at #1 after the edge that entered a SERVE state. Checks the
  // command for waitc cycles, then answers with pmem_resp for one cycle.
  // Returns at #1 after the edge back into IDLE.
  task automatic serve(input bit who, input logic [AW-1:0] addr,
                       input logic rd, input logic wr,
                       input logic [LW-1:0] wd, input int waitc,
                       input logic [LW-1:0] rdata);
    for (int k = 0; k <= waitc; k++) begin
      if (k == waitc) begin
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        exp_q.push_back('{who, rdata});
      end
      @(negedge clk);
      chk("cmd_read",  {255'd0, pmem_read},  {255'd0, rd});
      chk("cmd_write", {255'd0, pmem_write}, {255'd0, wr});
      chk("cmd_addr",  {224'd0, pmem_address}, {224'd0, addr});
      chk("cmd_wdata", pmem_wdata, wd);
      step();
    end
    pmem_resp = 1'b0;
  endtask

  task automatic idle_chk(input string name);
    @(negedge clk);
    chk({name, "_read"},  {255'd0, pmem_read},  256'd0);
    chk({name, "_write"}, {255'd0, pmem_write}, 256'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    // Reset state and combinational rdata fan-out
    repeat (2) step();
    pmem_rdata = {8{32'hdeadbeef}};
    @(negedge clk);
    chk("rst_read",   {255'd0, pmem_read},   256'd0);
    chk("rst_write",  {255'd0, pmem_write},  256'd0);
    chk("rst_iresp",  {255'd0, i_pmem_resp}, 256'd0);
    chk("rst_dresp",  {255'd0, d_pmem_resp}, 256'd0);
    chk("rst_i_rdata", i_pmem_rdata, {8{32'hdeadbeef}});
    chk("rst_d_rdata", d_pmem_rdata, {8{32'hdeadbeef}});
    step();
    reset = 1'b0;

    // I-only read, resp at cycle 4
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    idle_chk("i_c0");
    step();
    serve(WHO_I, 32'h0000_1000, 1'b1, 1'b0, '0, 3, {8{32'h1111_0001}});
    i_pmem_read = 1'b0;
    idle_chk("i_c5");
    step();

    // Requester drops mid-grant: still in SERVE_I until resp
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1040;
    step();
    i_pmem_read = 1'b0;
    serve(WHO_I, 32'h0000_1040, 1'b0, 1'b0, '0, 1, {8{32'h2222_0002}});
    idle_chk("drop_idle");
    step();

    // Tie after reset: I first (last_grant resets to D), D waits then follows
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_3000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_4000;
    step();
    serve(WHO_I, 32'h0000_3000, 1'b1, 1'b0, '0, 1, {8{32'h3333_0003}});
    i_pmem_read = 1'b0;
    idle_chk("tie_idle");
    step();
    serve(WHO_D, 32'h0000_4000, 1'b1, 1'b0, '0, 2, {8{32'h4444_0004}});
    d_pmem_read = 1'b0;
    idle_chk("tie_idle2");
    step();

    // D writeback
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_5000; d_pmem_wdata = WD_A5;
    step();
    serve(WHO_D, 32'h0000_5000, 1'b0, 1'b1, WD_A5, 1, {8{32'h5555_0005}});
    d_pmem_write = 1'b0;
    idle_chk("wb_idle");
    step();

    // Alternation with both held: I, D, I, D
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_6000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_7000;
    for (int t = 0; t < 4; t++) begin
      step();
      if (t % 2 == 0)
        serve(WHO_I, 32'h0000_6000, 1'b1, 1'b0, WD_A5, 0, {8{32'h6600_0000 + t}});
      else
        serve(WHO_D, 32'h0000_7000, 1'b1, 1'b0, WD_A5, 0, {8{32'h7700_0000 + t}});
      idle_chk("alt_idle");
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    step();

    // Reset mid-SERVE_D, then a stray resp in the following cycle
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_8000;
    step();
    @(negedge clk);
    chk("rstd_c1_read", {255'd0, pmem_read}, 256'd1);
    chk("rstd_c1_addr", {224'd0, pmem_address}, {224'd0, 32'h0000_8000});
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; d_pmem_read = 1'b0; pmem_resp = 1'b1;
    @(negedge clk);
    chk("rstd_c3_read",  {255'd0, pmem_read},   256'd0);
    chk("rstd_c3_dresp", {255'd0, d_pmem_resp}, 256'd0);
    chk("rstd_c3_addr",  {224'd0, pmem_address}, {224'd0, 32'h0000_6000});
    step();
    pmem_resp = 1'b0;
    // last_grant is D after that reset: a tie goes to I
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_9000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_a000;
    step();
    serve(WHO_I, 32'h0000_9000, 1'b1, 1'b0, WD_A5, 0, {8{32'h9999_0009}});
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    idle_chk("rstd_tie_idle");
    step();

    // Stray pmem_resp in IDLE: no resp, no state change
    pmem_resp = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_iresp", {255'd0, i_pmem_resp}, 256'd0);
      chk("stray_dresp", {255'd0, d_pmem_resp}, 256'd0);
      chk("stray_read",  {255'd0, pmem_read},   256'd0);
      step();
    end
    pmem_resp = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_b000;
    step();
    serve(WHO_I, 32'h0000_b000, 1'b1, 1'b0, WD_A5, 1, {8{32'hbbbb_000b}});
    i_pmem_read = 1'b0;
    idle_chk("stray_after");
    step();
    step();

    chk("queue_empty", exp_q.size(), 256'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The module SHALL have parameter line_width, default 256, meaning the cache-line data width in bits.
REQ-002 The module SHALL have parameter addr_width, default 32, meaning the physical address width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port i_pmem_read, input, 1 bit: instruction-cache line-read request.
REQ-006 The module SHALL have port i_pmem_address, input, addr_width bits: instruction-cache request address.
REQ-007 The module SHALL have port i_pmem_rdata, output, line_width bits: line data returned to the instruction cache.
REQ-008 The module SHALL have port i_pmem_resp, output, 1 bit: completion pulse to the instruction cache.
REQ-009 The module SHALL have port d_pmem_read, input, 1 bit: data-cache line-read request.
REQ-010 The module SHALL have port d_pmem_write, input, 1 bit: data-cache line-writeback request.
REQ-011 The module SHALL have port d_pmem_address, input, addr_width bits: data-cache request address.
REQ-012 The module SHALL have port d_pmem_wdata, input, line_width bits: data-cache writeback line.
REQ-013 The module SHALL have port d_pmem_rdata, output, line_width bits: line data returned to the data cache.
REQ-014 The module SHALL have port d_pmem_resp, output, 1 bit: completion pulse to the data cache.
REQ-015 The module SHALL have port pmem_read, output, 1 bit: read command to physical memory.
REQ-016 The module SHALL have port pmem_write, output, 1 bit: write command to physical memory.
REQ-017 The module SHALL have port pmem_address, output, addr_width bits: physical memory address.
REQ-018 The module SHALL have port pmem_wdata, output, line_width bits: physical memory write line.
REQ-019 The module SHALL have port pmem_rdata, input, line_width bits: physical memory read line.
REQ-020 The module SHALL have port pmem_resp, input, 1 bit: physical memory completion pulse.

Function
REQ-021 The module SHALL implement FSM states IDLE, SERVE_I and SERVE_D, plus a 1-bit last_grant register (I or D).
REQ-022 In IDLE, the module SHALL drive pmem_read=0, pmem_write=0, i_pmem_resp=0 and d_pmem_resp=0.
REQ-023 In IDLE with only i_pmem_read high, the next state SHALL be SERVE_I.
REQ-024 In IDLE with only d_pmem_read or d_pmem_write high, the next state SHALL be SERVE_D.
REQ-025 In IDLE with both requesters pending, the module SHALL grant the requester other than last_grant (round-robin).
REQ-026 On entering SERVE_I or SERVE_D, last_grant SHALL update to the granted requester in the same edge.
REQ-027 In SERVE_I, pmem_read SHALL equal i_pmem_read, pmem_write SHALL be 0, and pmem_address SHALL equal i_pmem_address.
REQ-028 In SERVE_D, pmem_read SHALL equal d_pmem_read, pmem_write SHALL equal d_pmem_write, pmem_address SHALL equal d_pmem_address, and pmem_wdata SHALL equal d_pmem_wdata.
REQ-029 pmem_wdata SHALL equal d_pmem_wdata in all states; pmem_address SHALL equal i_pmem_address outside SERVE_D.
REQ-030 i_pmem_rdata and d_pmem_rdata SHALL both equal pmem_rdata combinationally in all states.
REQ-031 i_pmem_resp SHALL equal pmem_resp while in SERVE_I and 0 otherwise; d_pmem_resp SHALL equal pmem_resp while in SERVE_D and 0 otherwise.
REQ-032 On pmem_resp=1 in SERVE_I or SERVE_D, the next state SHALL be IDLE, so each grant carries exactly one memory transaction.
REQ-033 Latency: a request first seen in IDLE at cycle N SHALL produce a memory command at cycle N+1; the response SHALL pass through in the same cycle as pmem_resp.
REQ-034 A requester dropping its request before pmem_resp SHALL NOT change state; the module SHALL remain in the SERVE state until pmem_resp.
REQ-035 Simultaneous d_pmem_read and d_pmem_write SHALL be forwarded unmodified; no priority is applied between them.
REQ-036 A request arriving during a SERVE state SHALL wait, with no response to it, until the module returns to IDLE.

Reset
REQ-037 On reset=1 at a clock edge, the state SHALL become IDLE and last_grant SHALL become D, independent of all other inputs.
REQ-038 A reset during SERVE_I or SERVE_D SHALL abandon the transaction; the next cycle SHALL show all command and resp outputs at 0.

Verification
REQ-039 I-only read: i_pmem_read=1, addr 0x0000_1000, pmem_resp at cycle 4 -> pmem_read=1 with addr 0x1000 in cycles 1-4, i_pmem_resp=1 at cycle 4 only, IDLE at cycle 5.
REQ-040 Tie after reset: both requests at cycle 0 -> SERVE_I first; after its resp, D (held high) is served next, cycle 1 after the return to IDLE.
REQ-041 D writeback: d_pmem_write=1, wdata 0xA5 repeated -> pmem_write=1, pmem_wdata matches, pmem_read=0, d_pmem_resp pulses with pmem_resp, i_pmem_resp stays 0.
REQ-042 Alternation: both requesters held for 4 transactions -> grant order I, D, I, D.
REQ-043 Reset mid-SERVE_D: reset at cycle 2 of a D read -> cycle 3 shows IDLE, pmem_read=0, d_pmem_resp=0, last_grant=D.
REQ-044 Stray pmem_resp in IDLE -> neither i_pmem_resp nor d_pmem_resp asserts, and the state is unchanged.
